// File: rtl/prco_decoder_sb.sv
// Purpose: PRCO instruction decoder (fetch -> execute) with a registered 2-entry skid buffer and a stall counter.
// Latency: 1 cycle from accept to q_p_valid; sustains 1 instruction/cycle when downstream is not stalled.
// Backpressure: q_p_stalled is registered (= skid entry valid); i_p_stalled/i_p_block hold the output stage.
module prco_decoder_sb #(
    parameter int IW    = 16,
    parameter int OPW   = 5,
    parameter int RW    = 3,
    parameter int IMMW  = 8,
    parameter int SIMMW = 5,
    parameter int DATAW = 16,
    parameter int CNTW  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_p_cp,
    input  logic             i_p_valid,
    output logic             q_p_stalled,
    input  logic [IW-1:0]    i_instr,
    input  logic             i_p_stalled,
    input  logic             i_p_block,
    output logic             q_p_valid,
    output logic [OPW-1:0]   q_op,
    output logic [RW-1:0]    q_seld,
    output logic [RW-1:0]    q_sela,
    output logic [IMMW-1:0]  q_imm8,
    output logic [DATAW-1:0] q_simm,
    output logic             q_reg_we,
    output logic             q_req_alu,
    output logic             q_req_ram,
    output logic             q_illegal,
    output logic [CNTW-1:0]  q_stall_cnt
);

    // ISA opcode encodings
    localparam logic [OPW-1:0] PRCO_OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] PRCO_OP_MOVI = OPW'(1);
    localparam logic [OPW-1:0] PRCO_OP_MOV  = OPW'(2);
    localparam logic [OPW-1:0] PRCO_OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] PRCO_OP_LW   = OPW'(4);
    localparam logic [OPW-1:0] PRCO_OP_SW   = OPW'(5);

    // One fully decoded instruction; both buffer stages hold this record.
    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [RW-1:0]    seld;
        logic [RW-1:0]    sela;
        logic [IMMW-1:0]  imm8;
        logic [DATAW-1:0] simm;
        logic             reg_we;
        logic             req_alu;
        logic             req_ram;
        logic             illegal;
    } rec_t;

    rec_t            w_dec;
    rec_t            r_out;
    rec_t            r_skid;
    logic            r_out_vld;
    logic            r_skid_vld;
    logic [CNTW-1:0] r_stall_cnt;

    logic            w_hold;
    logic            w_accept;
    logic            w_advance;
    logic            w_out_free;
    logic            w_cnt_sat;

    // Either downstream stall source holds the output stage identically.
    assign w_hold     = i_p_stalled | i_p_block;
    // A full skid entry is exactly the upstream stall, so accept only needs that bit.
    assign w_accept   = i_p_valid & ~r_skid_vld;
    assign w_advance  = r_out_vld & ~w_hold;
    // OUT can be (re)loaded this cycle when empty or being consumed.
    assign w_out_free = w_advance | ~r_out_vld;
    assign w_cnt_sat  = (r_stall_cnt == {CNTW{1'b1}});

    // Field extraction and opcode classification, purely from the incoming word.
    always_comb begin
        w_dec         = '0;
        w_dec.op      = i_instr[IW-1 -: OPW];
        w_dec.seld    = i_instr[IW-OPW-1 -: RW];
        w_dec.sela    = i_instr[IMMW-1 -: RW];
        w_dec.imm8    = i_instr[IMMW-1:0];
        w_dec.simm    = {{(DATAW-SIMMW){i_instr[SIMMW-1]}}, i_instr[SIMMW-1:0]};
        w_dec.reg_we  = 1'b0;
        w_dec.req_alu = 1'b0;
        w_dec.req_ram = 1'b0;
        w_dec.illegal = 1'b0;
        case (i_instr[IW-1 -: OPW])
            PRCO_OP_NOP: begin
            end
            PRCO_OP_MOVI, PRCO_OP_MOV: begin
                w_dec.reg_we = 1'b1;
            end
            PRCO_OP_ADD: begin
                w_dec.reg_we  = 1'b1;
                w_dec.req_alu = 1'b1;
            end
            PRCO_OP_LW: begin
                w_dec.reg_we  = 1'b1;
                w_dec.req_ram = 1'b1;
            end
            PRCO_OP_SW: begin
                w_dec.req_ram = 1'b1;
            end
            default: begin
                // Illegal opcodes still flow so execute can raise the exception.
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Stage valid bits: reset and flush clear both; otherwise SKID drains first, keeping FIFO order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (i_p_cp) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld  <= w_accept;
            end
        end else if (w_accept) begin
            r_skid_vld <= 1'b1;
        end
    end

    // Stage data: only reset clears it; flush leaves stale records behind invalid flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out  <= '0;
            r_skid <= '0;
        end else if (!i_p_cp) begin
            if (w_out_free) begin
                if (r_skid_vld) begin
                    r_out <= r_skid;
                end else if (w_accept) begin
                    r_out <= w_dec;
                end
            end else if (w_accept) begin
                r_skid <= w_dec;
            end
        end
    end

    // Saturating count of cycles with valid output held by downstream; survives flush.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_vld && w_hold && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
    end

    assign q_p_stalled = r_skid_vld;
    assign q_p_valid   = r_out_vld;
    assign q_op        = r_out.op;
    assign q_seld      = r_out.seld;
    assign q_sela      = r_out.sela;
    assign q_imm8      = r_out.imm8;
    assign q_simm      = r_out.simm;
    assign q_reg_we    = r_out.reg_we;
    assign q_req_alu   = r_out.req_alu;
    assign q_req_ram   = r_out.req_ram;
    assign q_illegal   = r_out.illegal;
    assign q_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_prco_decoder_sb.sv
// Purpose: directed self-checking bench for prco_decoder_sb (default widths plus a CNTW=4 copy).
// Latency: checks taken 1 time unit after each rising edge, inputs changed right after.
// Backpressure: exercises i_p_stalled hold, skid fill, flush and counter saturation.
module tb_prco_decoder_sb;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_p_cp;
    logic        i_p_valid;
    logic [15:0] i_instr;
    logic        i_p_stalled;
    logic        i_p_block;

    logic        q_p_stalled, q_p_valid;
    logic [4:0]  q_op;
    logic [2:0]  q_seld, q_sela;
    logic [7:0]  q_imm8;
    logic [15:0] q_simm;
    logic        q_reg_we, q_req_alu, q_req_ram, q_illegal;
    logic [15:0] q_stall_cnt;

    logic        s_p_stalled, s_p_valid;
    logic [4:0]  s_op;
    logic [2:0]  s_seld, s_sela;
    logic [7:0]  s_imm8;
    logic [15:0] s_simm;
    logic        s_reg_we, s_req_alu, s_req_ram, s_illegal;
    logic [3:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    prco_decoder_sb u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp), .i_p_valid(i_p_valid),
        .q_p_stalled(q_p_stalled), .i_instr(i_instr), .i_p_stalled(i_p_stalled),
        .i_p_block(i_p_block), .q_p_valid(q_p_valid), .q_op(q_op), .q_seld(q_seld),
        .q_sela(q_sela), .q_imm8(q_imm8), .q_simm(q_simm), .q_reg_we(q_reg_we),
        .q_req_alu(q_req_alu), .q_req_ram(q_req_ram), .q_illegal(q_illegal),
        .q_stall_cnt(q_stall_cnt)
    );

    prco_decoder_sb #(.CNTW(4)) u_sat (
        .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp), .i_p_valid(i_p_valid),
        .q_p_stalled(s_p_stalled), .i_instr(i_instr), .i_p_stalled(i_p_stalled),
        .i_p_block(i_p_block), .q_p_valid(s_p_valid), .q_op(s_op), .q_seld(s_seld),
        .q_sela(s_sela), .q_imm8(s_imm8), .q_simm(s_simm), .q_reg_we(s_reg_we),
        .q_req_alu(s_req_alu), .q_req_ram(s_req_ram), .q_illegal(s_illegal),
        .q_stall_cnt(s_stall_cnt)
    );

    // Instruction words (op[15:11] seld[10:8] low8[7:0]), hand-encoded:
    // ADD  seld=3 sela=5   : 00011 011 101 00000 = 16'h1BA0
    // MOVI seld=1 imm=0x7F : 00001 001 0111 1111 = 16'h097F
    // MOV  low5=10110      : 00010 000 0001 0110 = 16'h1016
    // MOV  low5=01010      : 00010 000 0000 1010 = 16'h100A
    // ILL  op=1F seld=7    : 11111 111 0101 0101 = 16'hFF55
    // LW   seld=2          : 00100 010 0000 0000 = 16'h2200
    // SW   seld=4          : 00101 100 0000 0000 = 16'h2C00

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_p_cp = 1'b0; i_p_valid = 1'b1; i_instr = 16'h1BA0;
        i_p_stalled = 1'b0; i_p_block = 1'b0;
        tick(); tick();
        checks++; if (q_p_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", q_p_valid); end
        checks++; if (q_p_stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %b want 0", q_p_stalled); end
        checks++; if (q_op !== 5'h00 || q_seld !== 3'd0 || q_sela !== 3'd0 || q_imm8 !== 8'h00 || q_simm !== 16'h0000)
            begin errors++; $display("FAIL reset_fields: got op=%h seld=%h sela=%h imm8=%h simm=%h want all 0", q_op, q_seld, q_sela, q_imm8, q_simm); end
        checks++; if ({q_reg_we, q_req_alu, q_req_ram, q_illegal} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {q_reg_we, q_req_alu, q_req_ram, q_illegal}); end
        checks++; if (q_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", q_stall_cnt); end
        i_reset = 1'b0; i_p_valid = 1'b0;
    endtask

    task automatic test_streaming();
        i_p_valid = 1'b1; i_instr = 16'h1BA0;
        tick();
        checks++; if (q_p_valid !== 1'b1) begin errors++; $display("FAIL stream_add_valid: got %b want 1", q_p_valid); end
        checks++; if (q_op !== 5'h03 || q_seld !== 3'd3 || q_sela !== 3'd5)
            begin errors++; $display("FAIL stream_add_fields: got op=%h seld=%0d sela=%0d want 03/3/5", q_op, q_seld, q_sela); end
        checks++; if ({q_reg_we, q_req_alu, q_req_ram, q_illegal} !== 4'b1100)
            begin errors++; $display("FAIL stream_add_ctrl: got %b want 1100", {q_reg_we, q_req_alu, q_req_ram, q_illegal}); end
        i_instr = 16'h097F;
        tick();
        checks++; if (q_p_valid !== 1'b1 || q_op !== 5'h01) begin errors++; $display("FAIL stream_movi_op: got v=%b op=%h want 1/01", q_p_valid, q_op); end
        checks++; if (q_imm8 !== 8'h7F) begin errors++; $display("FAIL stream_movi_imm8: got %h want 7f", q_imm8); end
        checks++; if ({q_reg_we, q_req_alu, q_req_ram, q_illegal} !== 4'b1000)
            begin errors++; $display("FAIL stream_movi_ctrl: got %b want 1000", {q_reg_we, q_req_alu, q_req_ram, q_illegal}); end
        i_p_valid = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", q_p_valid); end
    endtask

    task automatic test_sign_ext();
        i_p_valid = 1'b1; i_instr = 16'h1016;
        tick();
        checks++; if (q_simm !== 16'hFFF6) begin errors++; $display("FAIL simm_neg: got %h want fff6", q_simm); end
        i_instr = 16'h100A;
        tick();
        checks++; if (q_simm !== 16'h000A) begin errors++; $display("FAIL simm_pos: got %h want 000a", q_simm); end
        i_p_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        i_p_valid = 1'b1; i_instr = 16'hFF55;
        tick();
        checks++; if (q_p_valid !== 1'b1 || q_op !== 5'h1F) begin errors++; $display("FAIL ill_flow: got v=%b op=%h want 1/1f", q_p_valid, q_op); end
        checks++; if ({q_reg_we, q_req_alu, q_req_ram, q_illegal} !== 4'b0001)
            begin errors++; $display("FAIL ill_ctrl: got %b want 0001", {q_reg_we, q_req_alu, q_req_ram, q_illegal}); end
        i_instr = 16'h2200;
        tick();
        checks++; if ({q_reg_we, q_req_alu, q_req_ram, q_illegal} !== 4'b1010)
            begin errors++; $display("FAIL ill_next_lw: got %b want 1010", {q_reg_we, q_req_alu, q_req_ram, q_illegal}); end
        i_p_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_p_stalled = 1'b1; i_p_valid = 1'b1; i_instr = 16'h1BA0;   // A = ADD
        tick();
        checks++; if (q_p_valid !== 1'b1 || q_op !== 5'h03 || q_p_stalled !== 1'b0)
            begin errors++; $display("FAIL bp_a_out: got v=%b op=%h st=%b want 1/03/0", q_p_valid, q_op, q_p_stalled); end
        i_instr = 16'h2200;                                        // B = LW
        tick();
        checks++; if (q_p_stalled !== 1'b1 || q_op !== 5'h03)
            begin errors++; $display("FAIL bp_b_skid: got st=%b op=%h want 1/03", q_p_stalled, q_op); end
        i_instr = 16'h2C00;                                        // C = SW, must wait
        tick();
        tick();
        checks++; if (q_p_stalled !== 1'b1 || q_op !== 5'h03 || q_seld !== 3'd3)
            begin errors++; $display("FAIL bp_hold: got st=%b op=%h seld=%0d want 1/03/3", q_p_stalled, q_op, q_seld); end
        i_p_stalled = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b1 || q_op !== 5'h04 || q_seld !== 3'd2 || q_p_stalled !== 1'b0)
            begin errors++; $display("FAIL bp_b_out: got v=%b op=%h seld=%0d st=%b want 1/04/2/0", q_p_valid, q_op, q_seld, q_p_stalled); end
        tick();
        checks++; if (q_p_valid !== 1'b1 || q_op !== 5'h05 || q_seld !== 3'd4)
            begin errors++; $display("FAIL bp_c_out: got v=%b op=%h seld=%0d want 1/05/4", q_p_valid, q_op, q_seld); end
        i_p_valid = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", q_p_valid); end
        checks++; if (q_stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt: got %0d want 3", q_stall_cnt); end
    endtask

    task automatic test_block();
        i_p_valid = 1'b1; i_instr = 16'h097F; i_p_block = 1'b1;
        tick();
        i_p_valid = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b1 || q_op !== 5'h01 || q_stall_cnt !== 16'd4)
            begin errors++; $display("FAIL block_hold: got v=%b op=%h cnt=%0d want 1/01/4", q_p_valid, q_op, q_stall_cnt); end
        i_p_block = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b0) begin errors++; $display("FAIL block_release: got %b want 0", q_p_valid); end
    endtask

    task automatic test_flush();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_p_stalled = 1'b1; i_p_valid = 1'b1; i_instr = 16'h1BA0;
        tick();
        i_instr = 16'h2200;
        tick();
        checks++; if (q_p_stalled !== 1'b1 || q_stall_cnt !== 16'd1)
            begin errors++; $display("FAIL flush_setup: got st=%b cnt=%0d want 1/1", q_p_stalled, q_stall_cnt); end
        i_instr = 16'h2C00; i_p_cp = 1'b1; i_p_stalled = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b0 || q_p_stalled !== 1'b0)
            begin errors++; $display("FAIL flush_clear: got v=%b st=%b want 0/0", q_p_valid, q_p_stalled); end
        checks++; if (q_stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", q_stall_cnt); end
        checks++; if (q_op !== 5'h03) begin errors++; $display("FAIL flush_data_kept: got %h want 03", q_op); end
        i_p_cp = 1'b0; i_p_valid = 1'b0;
        tick();
        checks++; if (q_p_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", q_p_valid); end
    endtask

    task automatic test_saturation();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_p_stalled = 1'b1; i_p_valid = 1'b1; i_instr = 16'h1BA0;
        tick();
        i_p_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", s_stall_cnt); end
        checks++; if (q_stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d want 20", q_stall_cnt); end
        i_reset = 1'b1;
        tick();
        checks++; if (q_p_valid !== 1'b0 || q_op !== 5'h00 || q_seld !== 3'd0 || q_sela !== 3'd0 || q_imm8 !== 8'h00 || q_simm !== 16'h0)
            begin errors++; $display("FAIL sat_reset_fields: got v=%b op=%h seld=%h sela=%h imm=%h simm=%h want 0", q_p_valid, q_op, q_seld, q_sela, q_imm8, q_simm); end
        checks++; if ({q_reg_we, q_req_alu, q_req_ram, q_illegal, q_p_stalled} !== 5'b0)
            begin errors++; $display("FAIL sat_reset_ctrl: got %b want 00000", {q_reg_we, q_req_alu, q_req_ram, q_illegal, q_p_stalled}); end
        checks++; if (q_stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0)
            begin errors++; $display("FAIL sat_reset_cnt: got %0d/%0d want 0/0", q_stall_cnt, s_stall_cnt); end
        i_reset = 1'b0; i_p_stalled = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_sign_ext();
        test_illegal();
        test_back_pressure();
        test_block();
        test_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
